// File: rtl/checkout_scanner.sv
// Sequential checkout item checker: classifies each accepted scan as discounted
// and/or stolen, keeps saturating session tallies and latches a blinking alarm.
module checkout_scanner #(
  parameter int                      CODE_W        = 3,
  parameter logic [(2**CODE_W)-1:0]  DISCOUNT_SET  = 8'b1110_0100,
  parameter logic [(2**CODE_W)-1:0]  EXPENSIVE_SET = 8'b1010_0001,
  parameter int                      COUNT_W       = 8,
  parameter int                      BLINK_DIV     = 25_000_000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               scan_valid,
  input  logic [CODE_W-1:0]  scan_code,
  input  logic               scan_mark,
  input  logic               ack_alarm,
  output logic               scan_ready,
  output logic               discount,
  output logic               stolen,
  output logic               alarm,
  output logic               alarm_blink,
  output logic [COUNT_W-1:0] item_count,
  output logic [COUNT_W-1:0] discount_count,
  output logic [COUNT_W-1:0] stolen_count
);

  localparam int DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, ALARM} state_t;

  state_t             state_reg;
  logic [DIV_W-1:0]   div_reg;
  logic               blink_reg;
  logic               discount_reg;
  logic               stolen_reg;
  logic               accept;
  logic               hit_discount;
  logic               hit_stolen;
  logic [2:0]         cnt_inc;
  logic [COUNT_W-1:0] cnt_all [3];

  // Readiness depends only on the state register, never on scan inputs.
  assign scan_ready   = (state_reg != ALARM);
  assign accept       = scan_valid & scan_ready & ~clear;
  assign hit_discount = DISCOUNT_SET[scan_code];
  assign hit_stolen   = EXPENSIVE_SET[scan_code] & ~scan_mark;
  assign cnt_inc      = {hit_stolen, hit_discount, 1'b1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      div_reg      <= '0;
      blink_reg    <= 1'b0;
      discount_reg <= 1'b0;
      stolen_reg   <= 1'b0;
    end else if (clear) begin
      state_reg    <= IDLE;
      div_reg      <= '0;
      blink_reg    <= 1'b0;
      discount_reg <= 1'b0;
      stolen_reg   <= 1'b0;
    end else if (state_reg == ALARM) begin
      if (ack_alarm) begin
        state_reg <= ACTIVE;
        div_reg   <= '0;
        blink_reg <= 1'b0;
      end else if (div_reg == DIV_LAST) begin
        div_reg   <= '0;
        blink_reg <= ~blink_reg;
      end else begin
        div_reg <= div_reg + 1'b1;
      end
    end else if (accept) begin
      discount_reg <= hit_discount;
      stolen_reg   <= hit_stolen;
      if (hit_stolen) begin
        // Alarm starts lit with a fresh blink period.
        state_reg <= ALARM;
        div_reg   <= '0;
        blink_reg <= 1'b1;
      end else begin
        state_reg <= ACTIVE;
      end
    end
  end

  // Tally order: 0 = items, 1 = discounted, 2 = stolen; all saturate.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      logic [COUNT_W-1:0] cnt_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg <= '0;
        end else if (clear) begin
          cnt_reg <= '0;
        end else if (accept && cnt_inc[gi] && (cnt_reg != {COUNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      assign cnt_all[gi] = cnt_reg;
    end
  endgenerate

  assign discount       = discount_reg;
  assign stolen         = stolen_reg;
  assign alarm          = (state_reg == ALARM);
  assign alarm_blink    = blink_reg;
  assign item_count     = cnt_all[0];
  assign discount_count = cnt_all[1];
  assign stolen_count   = cnt_all[2];

endmodule

// File: tb/tb_checkout_scanner.sv
// Directed bench for checkout_scanner with 3-bit tallies and a 4-cycle blink.
module tb_checkout_scanner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       scan_valid;
  logic [2:0] scan_code;
  logic       scan_mark;
  logic       ack_alarm;
  logic       scan_ready;
  logic       discount;
  logic       stolen;
  logic       alarm;
  logic       alarm_blink;
  logic [2:0] item_count;
  logic [2:0] discount_count;
  logic [2:0] stolen_count;

  int checks = 0;
  int errors = 0;

  checkout_scanner #(
    .CODE_W(3),
    .DISCOUNT_SET(8'b1110_0100),
    .EXPENSIVE_SET(8'b1010_0001),
    .COUNT_W(3),
    .BLINK_DIV(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .clear(clear),
    .scan_valid(scan_valid),
    .scan_code(scan_code),
    .scan_mark(scan_mark),
    .ack_alarm(ack_alarm),
    .scan_ready(scan_ready),
    .discount(discount),
    .stolen(stolen),
    .alarm(alarm),
    .alarm_blink(alarm_blink),
    .item_count(item_count),
    .discount_count(discount_count),
    .stolen_count(stolen_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] code;
    logic       mark;
    logic       clr;
    logic       ack;
    logic       e_disc;
    logic       e_stol;
    logic       e_alarm;
    logic       e_blink;
    logic       e_ready;
    logic [2:0] e_ic;
    logic [2:0] e_dc;
    logic [2:0] e_sc;
  } vec_t;

  vec_t vecs [32];
  int   nvec = 0;

  task automatic add(input logic v, input logic [2:0] code, input logic mark,
                     input logic clr, input logic ack,
                     input logic d, input logic s, input logic a, input logic b,
                     input logic r, input logic [2:0] ic, input logic [2:0] dc,
                     input logic [2:0] sc);
    vecs[nvec] = '{v, code, mark, clr, ack, d, s, a, b, r, ic, dc, sc};
    nvec++;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic d, input logic s,
                           input logic a, input logic b, input logic r,
                           input logic [2:0] ic, input logic [2:0] dc,
                           input logic [2:0] sc);
    check({tag, ".discount"}, int'(discount), int'(d));
    check({tag, ".stolen"}, int'(stolen), int'(s));
    check({tag, ".alarm"}, int'(alarm), int'(a));
    check({tag, ".blink"}, int'(alarm_blink), int'(b));
    check({tag, ".ready"}, int'(scan_ready), int'(r));
    check({tag, ".item_count"}, int'(item_count), int'(ic));
    check({tag, ".discount_count"}, int'(discount_count), int'(dc));
    check({tag, ".stolen_count"}, int'(stolen_count), int'(sc));
  endtask

  task automatic drive(input logic v, input logic [2:0] code, input logic mark,
                       input logic clr, input logic ack);
    scan_valid = v;
    scan_code  = code;
    scan_mark  = mark;
    clear      = clr;
    ack_alarm  = ack;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    check_all("reset", 0, 0, 0, 0, 1, 0, 0, 0);
    $display("txn reset: ready=%0d alarm=%0d items=%0d", scan_ready, alarm, item_count);
    reset_n = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    //   v  code mark clr ack | disc stol alarm blink ready ic dc sc
    add(1, 3'd2, 0, 0, 0,  1, 0, 0, 0, 1, 1, 1, 0);
    add(1, 3'd5, 0, 0, 0,  1, 1, 1, 1, 0, 2, 2, 1);
    add(1, 3'd2, 0, 0, 0,  1, 1, 1, 1, 0, 2, 2, 1);
    add(0, 3'd0, 0, 0, 0,  1, 1, 1, 1, 0, 2, 2, 1);
    add(0, 3'd0, 0, 0, 0,  1, 1, 1, 1, 0, 2, 2, 1);
    add(0, 3'd0, 0, 0, 0,  1, 1, 1, 0, 0, 2, 2, 1);
    add(0, 3'd0, 0, 0, 0,  1, 1, 1, 0, 0, 2, 2, 1);
    add(1, 3'd2, 0, 0, 1,  1, 1, 0, 0, 1, 2, 2, 1);
    add(1, 3'd0, 1, 0, 0,  0, 0, 0, 0, 1, 3, 2, 1);
    add(1, 3'd0, 0, 0, 0,  0, 1, 1, 1, 0, 4, 2, 2);
    add(0, 3'd0, 0, 0, 1,  0, 1, 0, 0, 1, 4, 2, 2);
    add(1, 3'd7, 1, 0, 1,  1, 0, 0, 0, 1, 5, 3, 2);
    add(1, 3'd6, 0, 1, 0,  0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++)
      add(1, 3'd1, 0, 0, 0, 0, 0, 0, 0, 1, (i < 7) ? 3'(i + 1) : 3'd7, 0, 0);

    for (int i = 0; i < nvec; i++) begin
      drive(vecs[i].v, vecs[i].code, vecs[i].mark, vecs[i].clr, vecs[i].ack);
      $display("txn vec %0d: v=%0d code=%0d mark=%0d clr=%0d ack=%0d -> disc=%0d stol=%0d alarm=%0d blink=%0d ready=%0d ic=%0d dc=%0d sc=%0d",
               i, vecs[i].v, vecs[i].code, vecs[i].mark, vecs[i].clr, vecs[i].ack,
               discount, stolen, alarm, alarm_blink, scan_ready,
               item_count, discount_count, stolen_count);
      check_all($sformatf("vec%0d", i), vecs[i].e_disc, vecs[i].e_stol,
                vecs[i].e_alarm, vecs[i].e_blink, vecs[i].e_ready,
                vecs[i].e_ic, vecs[i].e_dc, vecs[i].e_sc);
    end

    // Blink over three half-periods: high for k=0..3, low 4..7, high 8..11.
    drive(1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      $display("txn blink k=%0d: alarm=%0d blink=%0d", k, alarm, alarm_blink);
      check($sformatf("blink_k%0d", k), int'(alarm_blink), ((k / 4) % 2 == 0) ? 1 : 0);
      check($sformatf("alarm_k%0d", k), int'(alarm), 1);
    end
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    $display("txn ack: alarm=%0d blink=%0d ready=%0d", alarm, alarm_blink, scan_ready);
    check("ack.alarm", int'(alarm), 0);
    check("ack.ready", int'(scan_ready), 1);

    // Asynchronous reset in the middle of an alarm, no clock edge in between.
    drive(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    check("pre_rst.alarm", int'(alarm), 1);
    scan_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    $display("txn async reset: alarm=%0d blink=%0d ready=%0d ic=%0d", alarm, alarm_blink, scan_ready, item_count);
    check_all("async_rst", 0, 0, 0, 0, 1, 0, 0, 0);
    #3;
    reset_n = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/checkout_scanner.md
# checkout_scanner

Sequential, parametrised item checker for the DE1_SoC checkout lab. It generalises the combinational discounted/stolen detector to an N-bit item code with parameter-defined discount and expensive sets. It accepts a stream of scans, keeps saturating item, discount and stolen tallies, and latches a blinking alarm until an operator acknowledges it. It sits between the switch/KEY input conditioning and the LEDR/HEX display logic of the DE1_SoC top level.

## Interface
Parameters:
- CODE_W, 3: item code width; code index is {U,P,C} at default width.
- DISCOUNT_SET, 8'b1110_0100: 2**CODE_W-bit mask; bit k set means code k is discounted.
- EXPENSIVE_SET, 8'b1010_0001: 2**CODE_W-bit mask; bit k set means code k must carry a mark.
- COUNT_W, 8: width of each tally counter.
- BLINK_DIV, 25_000_000: alarm_blink half-period in clk cycles; must be ≥1.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous session clear
- scan_valid  in  1  scan strobe, one cycle per item
- scan_code  in  CODE_W  item code
- scan_mark  in  1  security mark present (M)
- ack_alarm  in  1  operator alarm acknowledge
- scan_ready  out  1  scan is accepted this cycle when high
- discount  out  1  last accepted item is discounted
- stolen  out  1  last accepted item is expensive and unmarked
- alarm  out  1  alarm state active
- alarm_blink  out  1  blinking alarm indicator
- item_count, discount_count, stolen_count  out  COUNT_W  session tallies

## Operation
- States: IDLE, ACTIVE, ALARM.
- scan_ready = 1 in IDLE and ACTIVE; 0 in ALARM. A scan is accepted when scan_valid & scan_ready.
- On acceptance, with k = scan_code:
  - discount ← DISCOUNT_SET[k].
  - stolen ← EXPENSIVE_SET[k] & ~scan_mark.
  - item_count += 1; discount_count += discount; stolen_count += stolen.
  - Both flags may be set for the same item.
- Flags hold until the next accepted scan or clear.
- Counters saturate at 2**COUNT_W−1 and never wrap.
- Transitions:
  - IDLE→ACTIVE on an accepted non-stolen scan.
  - IDLE/ACTIVE→ALARM on an accepted stolen scan.
  - ALARM→ACTIVE on ack_alarm.
  - Any state→IDLE on clear.
  - ack_alarm outside ALARM is ignored.
- Blink behaviour:
  - In ALARM, a divider counts 0..BLINK_DIV−1 and alarm_blink toggles on each wrap.
  - Entering ALARM forces alarm_blink=1 and the divider to 0.
  - Outside ALARM, alarm_blink=0 and the divider is held at 0.
- Priority: clear > ack_alarm > scan.
  - Scan together with clear: ignored.
  - Scan together with ack in ALARM: ignored, because scan_ready is 0 that cycle.

## Timing
- Reset (reset_n low, asynchronous): state IDLE; all outputs 0 except scan_ready=1; all counters and the divider 0. Reset mid-ALARM drops the alarm immediately.
- Scan latency: a scan accepted at edge N updates flags, counters, state and alarm as visible outputs after edge N. There is no combinational path from scan inputs to outputs.
- scan_ready is a function of registered state only. It is 0 from the edge after a stolen scan is accepted until the edge after ack_alarm.
- clear sampled at edge N: all outputs return to reset values after edge N.
- Back-to-back scan_valid on consecutive cycles: every cycle is accepted while scan_ready=1.

## Test plan
- Reset, then a scan with code=2, mark=0:
  - discount=1, stolen=0, item_count=1, discount_count=1, state ACTIVE, alarm=0.
- Scan with code=5, mark=0:
  - stolen=1, discount=1, alarm=1 and alarm_blink=1 the next cycle, scan_ready=0.
  - A further scan with code=2 is ignored: item_count unchanged.
- BLINK_DIV=4 in ALARM:
  - alarm_blink toggles every 4 cycles.
  - ack_alarm → alarm=0, alarm_blink=0, scan_ready=1 next cycle.
  - ack_alarm and scan_valid in the same cycle: the scan is not counted.
- COUNT_W=3, 9 back-to-back scans with code=1, mark=0:
  - item_count saturates at 7.
  - discount_count=0 (bit 1 of DISCOUNT_SET is 0).
  - stolen_count=0 (bit 1 of EXPENSIVE_SET is 0).
- Code=0 with mark=1 → stolen=0. Code=0 with mark=0 → stolen=1 and alarm.
- Scan with clear in the same cycle → all counters 0, IDLE. reset_n pulsed low mid-ALARM → outputs at reset values with no clock edge required.
